// File: rtl/ram_slot_scheduler.sv
// Phi2-low RAM slot arbiter: video first, then DMA0/DMA1 during blanking.
// DMA_ROUND_ROBIN_EN selects burst-limited round robin; otherwise DMA0 has fixed priority.
module ram_slot_scheduler #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 19
) (
  input  logic              master_clock,
  input  logic              not_reset,
  input  logic              phi2,
  input  logic              video_active,
  input  logic [ADDR_W-1:0] video_addr,
  input  logic [1:0]        dma_req,
  input  logic [1:0]        dma_we,
  input  logic [ADDR_W-1:0] dma_addr0,
  input  logic [ADDR_W-1:0] dma_addr1,
  output logic [1:0]        slot_owner,
  output logic [1:0]        dma_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        burst_count
);

  typedef enum logic [1:0] {
    OWN_VIDEO = 2'b00,
    OWN_DMA0  = 2'b01,
    OWN_DMA1  = 2'b10,
    OWN_IDLE  = 2'b11
  } owner_t;

`ifdef DMA_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  localparam logic [3:0] BURST_LIM = 4'(BURST_LEN);

  owner_t            owner_reg, owner_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              we_reg, we_next;
  logic [3:0]        burst_reg, burst_next;
  logic              last_reg, last_next;   // 0 = DMA0, 1 = DMA1

  logic [ADDR_W-1:0] req_addr [2];
  logic              holding;
  logic              rr_pick;
  logic              sel;

  assign req_addr[0] = dma_addr0;
  assign req_addr[1] = dma_addr1;

  always_ff @(negedge master_clock or negedge not_reset) begin
    if (!not_reset) begin
      owner_reg <= OWN_IDLE;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      burst_reg <= 4'd0;
      last_reg  <= 1'b1;
    end else begin
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      we_reg    <= we_next;
      burst_reg <= burst_next;
      last_reg  <= last_next;
    end
  end

  // While a DMA requester owns the slot, last_reg names that same requester,
  // so "continue the holder" and "break the tie against last_holder" share one path.
  always_comb begin
    holding = (owner_reg == OWN_DMA0) || (owner_reg == OWN_DMA1);
    rr_pick = (holding && (burst_reg < BURST_LIM)) ? last_reg : ~last_reg;
    if (dma_req == 2'b11) begin
      sel = ROUND_ROBIN ? rr_pick : 1'b0;
    end else begin
      sel = dma_req[1];
    end
  end

  always_comb begin
    owner_next = owner_reg;
    addr_next  = addr_reg;
    we_next    = we_reg;
    burst_next = burst_reg;
    last_next  = last_reg;
    if (phi2) begin
      if (video_active) begin
        owner_next = OWN_VIDEO;
        addr_next  = video_addr;
        we_next    = 1'b0;
        burst_next = 4'd0;
      end else if (dma_req == 2'b00) begin
        owner_next = OWN_IDLE;
        we_next    = 1'b0;
        burst_next = 4'd0;
      end else begin
        owner_next = sel ? OWN_DMA1 : OWN_DMA0;
        addr_next  = req_addr[sel];
        we_next    = dma_we[sel];
        last_next  = sel;
        if (holding && (last_reg == sel)) begin
          burst_next = (burst_reg == 4'd15) ? 4'd15 : burst_reg + 4'd1;
        end else begin
          burst_next = 4'd1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      assign dma_grant[gi] = owner_reg[gi] & ~owner_reg[1-gi];
    end
  endgenerate

  assign slot_owner  = owner_reg;
  assign mem_addr    = addr_reg;
  assign mem_we      = we_reg;
  assign burst_count = burst_reg;

endmodule
